// File: rtl/uart_rx_frame_check_if.sv
// uart_rx_frame_check_if: sampler-side inputs and frame-result outputs of the UART RX frame checker
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  Frame_Start;
  logic                  Sample_Valid;
  logic                  Sampled_bit;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STP_2;
  logic                  Err_Clr;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Frame_Done;
  logic                  Str_err;
  logic                  Par_err;
  logic                  Stp_err;
  logic                  Busy;
  logic [CNT_WIDTH-1:0]  Str_cnt;
  logic [CNT_WIDTH-1:0]  Par_cnt;
  logic [CNT_WIDTH-1:0]  Stp_cnt;
  modport master (
    output Frame_Start, Sample_Valid, Sampled_bit, PAR_EN, PAR_TYP, STP_2, Err_Clr,
    input  P_DATA, Data_Valid, Frame_Done, Str_err, Par_err, Stp_err, Busy, Str_cnt, Par_cnt, Stp_cnt
  );
  modport slave (
    input  Frame_Start, Sample_Valid, Sampled_bit, PAR_EN, PAR_TYP, STP_2, Err_Clr,
    output P_DATA, Data_Valid, Frame_Done, Str_err, Par_err, Stp_err, Busy, Str_cnt, Par_cnt, Stp_cnt
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: walks a UART frame bit by bit, flags start/parity/stop errors and counts them
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input logic                 CLK,
  input logic                 RST,
  uart_rx_frame_check_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;
  state_t                r_state, w_next;
  logic                  r_par_en, r_par_typ, r_stp_2;
  logic                  r_str_err, r_par_err, r_stp_err;
  logic [DATA_WIDTH-1:0] r_shift, r_p_data;
  logic [BW-1:0]         r_bit_cnt;
  logic [CNT_WIDTH-1:0]  r_str_cnt, r_par_cnt, r_stp_cnt;
  logic                  w_sv, w_bit, w_last, w_par_exp, w_done, w_start;
  assign w_sv      = bus.Sample_Valid;
  assign w_bit     = bus.Sampled_bit;
  assign w_last    = r_bit_cnt == BW'(DATA_WIDTH - 1);
  assign w_par_exp = ^r_shift ^ r_par_typ;
  assign w_done    = r_state == DONE;
  assign w_start   = r_state == IDLE && bus.Frame_Start;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.Frame_Start ? START : IDLE;
      START:   w_next = !w_sv ? START : w_bit ? DONE : DATA;
      DATA:    w_next = !(w_sv && w_last) ? DATA : r_par_en ? PARITY : STOP1;
      PARITY:  w_next = w_sv ? STOP1 : PARITY;
      STOP1:   w_next = !w_sv ? STOP1 : r_stp_2 ? STOP2 : DONE;
      STOP2:   w_next = w_sv ? DONE : STOP2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      {r_par_en, r_par_typ, r_stp_2, r_str_err, r_par_err, r_stp_err} <= '0;
      r_shift   <= '0;
      r_p_data  <= '0;
      r_bit_cnt <= '0;
      r_str_cnt <= '0;
      r_par_cnt <= '0;
      r_stp_cnt <= '0;
    end else begin
      if (w_start) begin
        {r_par_en, r_par_typ, r_stp_2} <= {bus.PAR_EN, bus.PAR_TYP, bus.STP_2};
        {r_str_err, r_par_err, r_stp_err} <= '0;
        r_bit_cnt <= '0;
      end
      if (w_sv) begin
        if (r_state == START && w_bit) r_str_err <= 1'b1;
        if (r_state == DATA) begin
          r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (r_state == PARITY && w_bit != w_par_exp) r_par_err <= 1'b1;
        if ((r_state == STOP1 || r_state == STOP2) && !w_bit) r_stp_err <= 1'b1;
      end
      // only the stop-bit path reaches DONE with a full word; an aborted start keeps the old P_DATA
      if (w_next == DONE && r_state != START && r_state != DONE) r_p_data <= r_shift;
      r_str_cnt <= bus.Err_Clr ? '0 : (w_done && r_str_err && !(&r_str_cnt)) ? r_str_cnt + 1'b1 : r_str_cnt;
      r_par_cnt <= bus.Err_Clr ? '0 : (w_done && r_par_err && !(&r_par_cnt)) ? r_par_cnt + 1'b1 : r_par_cnt;
      r_stp_cnt <= bus.Err_Clr ? '0 : (w_done && r_stp_err && !(&r_stp_cnt)) ? r_stp_cnt + 1'b1 : r_stp_cnt;
    end
  assign bus.P_DATA     = r_p_data;
  assign bus.Frame_Done = w_done;
  assign bus.Data_Valid = w_done && !(r_str_err || r_par_err || r_stp_err);
  assign bus.Str_err    = r_str_err;
  assign bus.Par_err    = r_par_err;
  assign bus.Stp_err    = r_stp_err;
  assign bus.Busy       = r_state != IDLE;
  assign bus.Str_cnt    = r_str_cnt;
  assign bus.Par_cnt    = r_par_cnt;
  assign bus.Stp_cnt    = r_stp_cnt;
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check: random UART frames against a frame-level reference model and result scoreboard
module tb_uart_rx_frame_check;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
  typedef struct {
    logic          str;
    logic          par;
    logic          stp;
    logic [DW-1:0] d;
  } exp_t;
  logic clk, rst_n;
  int   n_checks, n_fail;
  bit   clr_next, rand_en;
  exp_t q[$];
  int   m_sc, m_pc, m_tc;
  logic [DW-1:0] m_pd;
  uart_rx_frame_check_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.CLK(clk), .RST(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_pdata"}, 32'(bus.P_DATA), 0);
    chk({n, "_dv"}, 32'(bus.Data_Valid), 0);
    chk({n, "_done"}, 32'(bus.Frame_Done), 0);
    chk({n, "_errs"}, 32'({bus.Str_err, bus.Par_err, bus.Stp_err}), 0);
    chk({n, "_busy"}, 32'(bus.Busy), 0);
    chk({n, "_cnts"}, 32'({bus.Str_cnt, bus.Par_cnt, bus.Stp_cnt}), 0);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    bus.Err_Clr = clr_next || (rand_en && $urandom_range(0, 23) == 0);
    clr_next = 1'b0;
  endtask
  task automatic send_bit(input bit b, input bit clr);
    repeat ($urandom_range(0, 2)) begin
      bus.Sample_Valid = 1'b0;
      bus.Sampled_bit  = 1'($urandom);
      bus.Frame_Start  = $urandom_range(0, 5) == 0;
      step();
    end
    bus.Frame_Start  = 1'b0;
    bus.Sample_Valid = 1'b1;
    bus.Sampled_bit  = b;
    clr_next = clr;
    step();
    bus.Sample_Valid = 1'b0;
  endtask
  task automatic frame(input bit pe, pt, s2, input logic [DW-1:0] d, input bit sb, pb, e1, e2, clr);
    exp_t e;
    repeat ($urandom_range(0, 2)) begin
      bus.Sample_Valid = 1'($urandom);
      bus.Sampled_bit  = 1'($urandom);
      step();
    end
    bus.Sample_Valid = 1'b0;
    {bus.PAR_EN, bus.PAR_TYP, bus.STP_2} = {pe, pt, s2};
    bus.Frame_Start = 1'b1;
    step();
    bus.Frame_Start = 1'b0;
    {bus.PAR_EN, bus.PAR_TYP, bus.STP_2} = 3'($urandom);
    e.str = sb;
    e.par = !sb && pe && pb;
    e.stp = !sb && (e1 || (s2 && e2));
    e.d   = d;
    q.push_back(e);
    if (sb) send_bit(1'b1, clr);
    else begin
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < DW; i++) send_bit(d[i], 1'b0);
      if (pe) send_bit((^d) ^ pt ^ pb, 1'b0);
      send_bit(!e1, s2 ? 1'b0 : clr);
      if (s2) send_bit(!e2, clr);
    end
    chk("done_latency", 32'(bus.Frame_Done), 1);
    chk("done_busy", 32'(bus.Busy), 1);
    step();
    chk("done_single_cycle", 32'(bus.Frame_Done), 0);
    chk("idle_busy", 32'(bus.Busy), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    have = 1'b0;
    if (!rst_n) begin
      m_sc = 0;
      m_pc = 0;
      m_tc = 0;
      m_pd = '0;
    end else begin
      chk("str_cnt", 32'(bus.Str_cnt), m_sc);
      chk("par_cnt", 32'(bus.Par_cnt), m_pc);
      chk("stp_cnt", 32'(bus.Stp_cnt), m_tc);
      if (bus.Frame_Done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got Frame_Done=1 expected no frame pending at %0t", $time);
        end else begin
          e = q.pop_front();
          have = 1'b1;
          if (!e.str) m_pd = e.d;
          chk("str_err", 32'(bus.Str_err), 32'(e.str));
          chk("par_err", 32'(bus.Par_err), 32'(e.par));
          chk("stp_err", 32'(bus.Stp_err), 32'(e.stp));
          chk("data_valid", 32'(bus.Data_Valid), 32'(!(e.str || e.par || e.stp)));
        end
      end else chk("data_valid_idle", 32'(bus.Data_Valid), 0);
      chk("p_data", 32'(bus.P_DATA), 32'(m_pd));
      if (bus.Err_Clr) begin
        m_sc = 0;
        m_pc = 0;
        m_tc = 0;
      end else if (have) begin
        if (e.str && m_sc < MAXC) m_sc++;
        if (e.par && m_pc < MAXC) m_pc++;
        if (e.stp && m_tc < MAXC) m_tc++;
      end
    end
  end
  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_next = 1'b0;
    rand_en  = 1'b0;
    {bus.Frame_Start, bus.Sample_Valid, bus.Sampled_bit, bus.PAR_EN, bus.PAR_TYP, bus.STP_2, bus.Err_Clr} = '0;
    rst_n = 1'b0;
    #3;
    chk_zero("reset");
    #9 rst_n = 1'b1;
    step();
    frame(0, 0, 0, 8'hA5, 0, 0, 0, 0, 0);
    frame(1, 0, 0, 8'h07, 0, 1, 0, 0, 0);
    frame(0, 0, 0, 8'h5A, 1, 0, 0, 0, 0);
    repeat (3) begin
      bus.Sample_Valid = 1'b1;
      bus.Sampled_bit  = 1'($urandom);
      step();
    end
    bus.Sample_Valid = 1'b0;
    frame(0, 0, 1, 8'h33, 0, 0, 0, 1, 0);
    frame(1, 1, 1, 8'hC3, 0, 0, 0, 0, 0);
    repeat (3) frame(0, 0, 0, 8'($urandom), 0, 0, 1, 0, 0);
    frame(0, 0, 0, 8'h11, 0, 0, 1, 0, 1);
    frame(0, 0, 0, 8'h22, 0, 0, 1, 0, 0);
    {bus.PAR_EN, bus.PAR_TYP, bus.STP_2} = 3'b000;
    bus.Frame_Start = 1'b1;
    step();
    bus.Frame_Start = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_abort");
    step();
    step();
    chk_zero("reset_hold");
    rst_n = 1'b1;
    step();
    frame(0, 0, 0, 8'h3C, 0, 0, 0, 0, 0);
    rand_en = 1'b1;
    for (int k = 0; k < 250; k++)
      frame(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0);
    rand_en = 1'b0;
    repeat (4) step();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
Parametrised successor to the UART RX single-bit start check. It consumes one sampled bit per bit-period from the data sampler and walks the whole frame: start, DATA_WIDTH data bits LSB-first, optional parity, and 1 or 2 stop bits. It reports start, parity and stop errors per frame, presents the received word, and keeps saturating error counters. It sits between data sampling and the RX output register in UART_RX.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9)
CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
Frame_Start  input  1  single-cycle pulse from the RX FSM when the start edge is detected
Sample_Valid  input  1  single-cycle pulse when Sampled_bit holds a new bit
Sampled_bit  input  1  majority-sampled bit value
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STP_2  input  1  0 = one stop bit, 1 = two stop bits
Err_Clr  input  1  synchronous clear of all error counters
P_DATA  output  DATA_WIDTH  received word, held until the next Frame_Done
Data_Valid  output  1  one-cycle pulse when a frame completes with no error
Frame_Done  output  1  one-cycle pulse at the end of every frame, including aborted frames
Str_err  output  1  start error, valid in the Frame_Done cycle
Par_err  output  1  parity error, valid in the Frame_Done cycle
Stp_err  output  1  stop error, valid in the Frame_Done cycle
Busy  output  1  high when the FSM is not in IDLE
Str_cnt, Par_cnt, Stp_cnt  output  CNT_WIDTH each  saturating error counters

Behaviour:
- Reset: FSM goes to IDLE. Every output is 0, including P_DATA and the counters.
- A reset asserted mid-frame aborts the frame immediately. No Frame_Done is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE -> START on Frame_Start. PAR_EN, PAR_TYP and STP_2 are latched at this point and held for the whole frame.
- Sample_Valid in IDLE is ignored. Frame_Start outside IDLE is ignored.
- All other transitions happen only on cycles where Sample_Valid=1. Each of those cycles consumes exactly one bit.
- START:
  - Bit=1: set Str_err and go to DONE. The frame is aborted; no further bits are consumed.
  - Bit=0: go to DATA.
- DATA:
  - The bit is shifted into a DATA_WIDTH shift register, LSB first.
  - A bit counter runs 0..DATA_WIDTH-1.
  - After the last bit: go to PARITY if PAR_EN, else STOP1.
- PARITY:
  - Expected bit = XOR of the data bits (even), or its inverse (odd).
  - A mismatch sets Par_err. Then go to STOP1.
- STOP1:
  - Bit=0 sets Stp_err.
  - Next state is STOP2 if STP_2, else DONE.
- STOP2: bit=0 sets Stp_err, then go to DONE.
- DONE (one cycle):
  - Frame_Done=1.
  - P_DATA is updated from the shift register, but only if Str_err=0.
  - Data_Valid = ~(Str_err|Par_err|Stp_err).
  - The error counters increment, then the FSM returns to IDLE.
- Latency: Frame_Done occurs the cycle after the Sample_Valid of the final stop bit, or of the failing start bit.
- Str_err, Par_err and Stp_err are cleared when leaving IDLE. They hold their value until the next Frame_Start.
- Counters:
  - Each counter increments by 1 per frame whose corresponding error flag is set.
  - Counters saturate at 2^CNT_WIDTH-1.
  - Err_Clr has priority over a same-cycle increment: the result is 0.
- Sampled_bit is ignored on cycles where Sample_Valid=0.

Test Plan:
1. Reset, then DATA_WIDTH=8, PAR_EN=0, STP_2=0, send start 0, data 0xA5 LSB-first, stop 1 -> P_DATA=0xA5; Data_Valid and Frame_Done high for exactly 1 cycle; all error flags 0; counters 0.
2. PAR_EN=1, PAR_TYP=0, data 0x07, parity bit 0 (expected 1) -> Par_err=1, Data_Valid=0, P_DATA=0x07, Par_cnt=1.
3. Start bit sampled 1 -> Str_err=1 and Frame_Done 1 cycle after that sample; Busy drops; later Sample_Valid pulses do not change any output; Str_cnt=1.
4. STP_2=1, first stop bit 1, second stop bit 0 -> Stp_err=1, Stp_cnt=1. Repeat with both stop bits 1 -> no error, Data_Valid=1.
5. CNT_WIDTH=2, send 4 frames with stop errors -> Stp_cnt sequence is 1,2,3,3 (saturates). Assert Err_Clr in the same cycle as a 5th Frame_Done -> Stp_cnt=0.
6. Assert RST low after 4 data bits -> all outputs 0 asynchronously and no Frame_Done. Release RST and send a clean frame 0x3C -> Data_Valid=1, P_DATA=0x3C.
